// File: rtl/vga_framebuffer_scan.sv
// 160x120x12 frame buffer written from the sequencer's pixel stream and scanned out as
// 640x480@60 VGA with 4x4 replication. Define VGA_BORDER_EN to paint the visible-area edge white.
module vga_framebuffer_scan #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE_SH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        wr_en,
  input  logic [7:0]  CounterX,
  input  logic [7:0]  CounterY,
  input  logic [11:0] color,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int AW       = $clog2(FB_DEPTH);

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_END  = 10'(H_VIS);
  localparam logic [9:0] V_END  = 10'(V_VIS);
  localparam logic [9:0] HS_LO  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [8:0] X_LIM  = 9'(FB_W);
  localparam logic [8:0] Y_LIM  = 9'(FB_H);

  // Row base y*FB_W as a sum of shifted copies of y, one per set bit of FB_W.
  function automatic logic [14:0] times_fb_w(input logic [14:0] y);
    logic [14:0] acc;
    acc = '0;
    for (int i = 0; i < 15; i++)
      if (FB_W[i]) acc = acc + (y << i);
    return acc;
  endfunction

  logic [9:0]  h_cnt, v_cnt;
  logic        active, hs_raw, vs_raw;
  logic [14:0] scan_addr;
  logic        wr_ok;
  logic [14:0] wr_addr;
  logic [11:0] mem [FB_DEPTH];
  logic [14:0] rd_addr;
  logic [11:0] rd_data;
  logic        act1, hs1, vs1;
  logic        act2;
  logic [11:0] pix;

  // NOTE: sequential state always uses <=, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign active    = (h_cnt < H_END) && (v_cnt < V_END);
  assign hs_raw    = !((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
  assign vs_raw    = !((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
  assign scan_addr = times_fb_w(15'(v_cnt >> SCALE_SH)) + 15'(h_cnt >> SCALE_SH);

  assign wr_ok   = wr_en && ({1'b0, CounterX} < X_LIM) && ({1'b0, CounterY} < Y_LIM);
  assign wr_addr = times_fb_w({7'b0, CounterY}) + {7'b0, CounterX};

  // NOTE: the RAM and its read register carry no reset so they map onto block RAM;
  // the reset-cleared act2 flag hides rd_data until valid data has been read.
  always_ff @(posedge clk) begin
    if (wr_ok)  mem[wr_addr[AW-1:0]] <= color;
    if (pix_en) rd_data <= mem[rd_addr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      act1    <= 1'b0;
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      act2    <= 1'b0;
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
    end else if (pix_en) begin
      rd_addr <= scan_addr;
      act1    <= active;
      hs1     <= hs_raw;
      vs1     <= vs_raw;
      act2    <= act1;
      vga_hs  <= hs1;
      vga_vs  <= vs1;
    end
  end

`ifdef VGA_BORDER_EN
  logic edge_raw, bd1, bd2;

  assign edge_raw = active && ((h_cnt == 10'd0) || (h_cnt == H_END - 10'd1) ||
                               (v_cnt == 10'd0) || (v_cnt == V_END - 10'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bd1 <= 1'b0;
      bd2 <= 1'b0;
    end else if (pix_en) begin
      bd1 <= edge_raw;
      bd2 <= bd1;
    end
  end
`endif

  // NOTE: pix gets a default first so no path through this block infers a latch.
  always_comb begin
    pix = '0;
    if (act2) pix = rd_data;
`ifdef VGA_BORDER_EN
    if (act2 && bd2) pix = 12'hFFF;
`endif
  end

  assign {vga_r, vga_g, vga_b} = pix;
  assign frame_start = pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule
